// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit arbiter: FSM encoding, requester
// indices and the grant encoding helper.
package uart_pkg;

  localparam int CHAR_W = 8;

  localparam logic REQ_DEBUG   = 1'b0;
  localparam logic REQ_CONSOLE = 1'b1;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SEND      = 2'd1,
    WAIT_LOW  = 2'd2,
    WAIT_HIGH = 2'd3
  } state_t;

  function automatic logic [1:0] req_onehot(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester strobes, FIFO status and transmitter handshake of the arbiter.
interface uart_tx_arbiter_if;
  import uart_pkg::*;

  logic              req0_valid;
  logic [CHAR_W-1:0] req0_char;
  logic              req1_valid;
  logic [CHAR_W-1:0] req1_char;
  logic              busy0;
  logic              busy1;
  logic              drop0;
  logic              drop1;
  logic              tx_ready;
  logic              tx_send;
  logic [CHAR_W-1:0] tx_data;
  logic [1:0]        grant;

  modport master (
    output req0_valid, req0_char, req1_valid, req1_char, tx_ready,
    input  busy0, busy1, drop0, drop1, tx_send, tx_data, grant
  );

  modport slave (
    input  req0_valid, req0_char, req1_valid, req1_char, tx_ready,
    output busy0, busy1, drop0, drop1, tx_send, tx_data, grant
  );

endinterface

// File: rtl/char_fifo.sv
// Per-requester character FIFO; a push into a full FIFO is still taken when
// the head is popped in the same cycle, otherwise it is dropped.
module char_fifo #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] din,
  input  logic              pop,
  output logic [DATA_W-1:0] head,
  output logic              empty,
  output logic              full,
  output logic              drop
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [AW:0]       count;
  logic [AW:0]       count_nx;
  logic              full_q;
  logic              do_pop;
  logic              accept;

  assign do_pop = pop && (count != '0);
  assign accept = push && (!full_q || do_pop);

  always_comb begin
    count_nx = count;
    case ({accept, do_pop})
      2'b10:   count_nx = count + 1'b1;
      2'b01:   count_nx = count - 1'b1;
      default: count_nx = count;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full_q <= 1'b0;
    end else begin
      if (accept) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      count  <= count_nx;
      full_q <= (count_nx == FULL_CNT);
    end
  end

  // When full, the write lands on the slot being read out this cycle.
  always_ff @(posedge clk) begin
    if (accept) mem[wr_ptr] <= din;
  end

  assign head  = mem[rd_ptr];
  assign empty = (count == '0);
  assign full  = full_q;
  assign drop  = push && full_q && !do_pop;

endmodule

// File: rtl/uart_tx_arbiter.sv
// Two-requester UART transmit arbiter: per-requester FIFOs, round-robin with
// a line lock that holds the transmitter until NEWLINE or an idle timeout.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int          DEPTH        = 4,
  parameter int          LOCK_TIMEOUT = 255,
  parameter logic [7:0]  NEWLINE      = 8'h0A,
  parameter int          ACK_TIMEOUT  = 16
) (
  input logic              clk,
  input logic              rst,
  uart_tx_arbiter_if.slave bus
);

  localparam int LT_W = $clog2(LOCK_TIMEOUT + 1);
  localparam int AT_W = $clog2(ACK_TIMEOUT + 1);
  localparam logic [LT_W-1:0] LT_LAST = LT_W'(LOCK_TIMEOUT - 1);
  localparam logic [AT_W-1:0] AT_LAST = AT_W'(ACK_TIMEOUT - 1);

  state_t            state_q;
  state_t            state_d;
  logic [CHAR_W-1:0] head_v [2];
  logic [1:0]        empty_v;
  logic [1:0]        full_v;
  logic [1:0]        drop_v;
  logic [1:0]        pop_v;
  logic [1:0]        elig;
  logic              sel;
  logic              take;
  logic [CHAR_W-1:0] pop_char;

  logic [CHAR_W-1:0] data_q;
  logic              owner_q;
  logic              prio_q;
  logic              lock_q;
  logic              lock_owner_q;
  logic [LT_W-1:0]   lock_tmr_q;
  logic [AT_W-1:0]   ack_tmr_q;

  char_fifo #(.DEPTH(DEPTH), .DATA_W(CHAR_W)) u_fifo0 (
    .clk   (clk),
    .rst   (rst),
    .push  (bus.req0_valid),
    .din   (bus.req0_char),
    .pop   (pop_v[REQ_DEBUG]),
    .head  (head_v[REQ_DEBUG]),
    .empty (empty_v[REQ_DEBUG]),
    .full  (full_v[REQ_DEBUG]),
    .drop  (drop_v[REQ_DEBUG])
  );

  char_fifo #(.DEPTH(DEPTH), .DATA_W(CHAR_W)) u_fifo1 (
    .clk   (clk),
    .rst   (rst),
    .push  (bus.req1_valid),
    .din   (bus.req1_char),
    .pop   (pop_v[REQ_CONSOLE]),
    .head  (head_v[REQ_CONSOLE]),
    .empty (empty_v[REQ_CONSOLE]),
    .full  (full_v[REQ_CONSOLE]),
    .drop  (drop_v[REQ_CONSOLE])
  );

  // A held lock narrows eligibility to its owner; otherwise prio_q breaks ties.
  always_comb begin
    elig[REQ_DEBUG]   = !empty_v[REQ_DEBUG]   && (!lock_q || lock_owner_q == REQ_DEBUG);
    elig[REQ_CONSOLE] = !empty_v[REQ_CONSOLE] && (!lock_q || lock_owner_q == REQ_CONSOLE);
    sel      = (elig == 2'b11) ? prio_q : elig[REQ_CONSOLE];
    take     = (state_q == IDLE) && bus.tx_ready && (elig != 2'b00);
    pop_v    = '0;
    pop_v[sel] = take;
    pop_char = head_v[sel];
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:      if (take) state_d = SEND;
      SEND:      state_d = WAIT_LOW;
      WAIT_LOW:  begin
        if (!bus.tx_ready)           state_d = WAIT_HIGH;
        else if (ack_tmr_q == AT_LAST) state_d = IDLE;
      end
      WAIT_HIGH: if (bus.tx_ready) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      ack_tmr_q <= '0;
    end else begin
      state_q   <= state_d;
      ack_tmr_q <= (state_q == WAIT_LOW) ? ack_tmr_q + 1'b1 : '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q       <= '0;
      owner_q      <= REQ_DEBUG;
      prio_q       <= REQ_DEBUG;
      lock_q       <= 1'b0;
      lock_owner_q <= REQ_DEBUG;
      lock_tmr_q   <= '0;
    end else if (take) begin
      data_q       <= pop_char;
      owner_q      <= sel;
      prio_q       <= ~sel;
      lock_q       <= (pop_char != NEWLINE);
      lock_owner_q <= sel;
      lock_tmr_q   <= '0;
    end else if (lock_q && state_q == IDLE && empty_v[lock_owner_q]) begin
      if (lock_tmr_q == LT_LAST) begin
        lock_q     <= 1'b0;
        lock_tmr_q <= '0;
      end else begin
        lock_tmr_q <= lock_tmr_q + 1'b1;
      end
    end
  end

  always_comb begin
    bus.grant = 2'b00;
    if (state_q != IDLE) bus.grant = req_onehot(owner_q);
    else if (lock_q)     bus.grant = req_onehot(lock_owner_q);
  end

  assign bus.tx_send = (state_q == SEND);
  assign bus.tx_data = data_q;
  assign bus.busy0   = full_v[REQ_DEBUG];
  assign bus.busy1   = full_v[REQ_CONSOLE];
  assign bus.drop0   = drop_v[REQ_DEBUG];
  assign bus.drop1   = drop_v[REQ_CONSOLE];

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 SHALL have parameter DEPTH, default 4, per-requester FIFO entries (power of 2, min 2).
REQ-002 SHALL have parameter LOCK_TIMEOUT, default 255, idle cycles before a line lock is abandoned.
REQ-003 SHALL have parameter NEWLINE, default 8'h0A, character that ends a line lock.
REQ-004 SHALL have parameter ACK_TIMEOUT, default 16, cycles to wait for tx_ready to fall after a send.
REQ-005 SHALL have ports `clk  in  1  sole clock`; `rst  in  1  asynchronous, active-high reset`.
REQ-006 SHALL have ports `req0_valid  in  1  one-cycle char strobe, requester 0 (debug stream)`; `req0_char  in  8  character`.
REQ-007 SHALL have ports `req1_valid  in  1  one-cycle char strobe, requester 1 (console stream)`; `req1_char  in  8  character`.
REQ-008 SHALL have ports `busy0 / busy1  out  1  FIFO full, per requester`; `drop0 / drop1  out  1  one-cycle overflow pulse`.
REQ-009 SHALL have ports `tx_ready  in  1  transmitter idle, synchronous to clk`; `tx_send  out  1  one-cycle send pulse`; `tx_data  out  8  character, stable from send until return to IDLE`.
REQ-010 SHALL have port `grant  out  2  one-hot current owner, 0 when none`.

Function
REQ-011 Each requester SHALL have its own DEPTH-entry FIFO; a push occurs when reqN_valid=1.
REQ-012 A push SHALL be accepted when the FIFO is not full, or when it is full and popped in the same cycle.
REQ-013 Any other push to a full FIFO SHALL be discarded, and dropN SHALL pulse high for exactly that cycle.
REQ-014 busyN SHALL equal (count == DEPTH), registered alongside the count; FIFO pointers SHALL wrap modulo DEPTH.
REQ-015 The FSM SHALL have the four states IDLE, SEND, WAIT_LOW and WAIT_HIGH.
REQ-016 IDLE: if tx_ready=1 and an eligible FIFO is non-empty, the block SHALL pop its head into tx_data, set grant to that requester, and go to SEND.
REQ-017 SEND: tx_send SHALL be 1 for exactly this one cycle, then the FSM SHALL go to WAIT_LOW.
REQ-018 WAIT_LOW: on tx_ready=0 the FSM SHALL go to WAIT_HIGH; after ACK_TIMEOUT cycles without it, the FSM SHALL go to IDLE.
REQ-019 WAIT_HIGH: on tx_ready=1 the FSM SHALL go to IDLE.
REQ-020 Throughput SHALL be at most one character per IDLE->SEND->WAIT_LOW->WAIT_HIGH round.
REQ-021 Latency from a push into an empty FIFO (transmitter idle, no lock) to tx_send SHALL be 2 cycles (push -> pop in IDLE -> SEND).
REQ-022 Eligibility with no lock SHALL be round-robin: when both FIFOs are non-empty, the requester not served last SHALL win; after reset requester 0 SHALL win.
REQ-023 Popping a character other than NEWLINE SHALL set the lock to that requester.
REQ-024 Popping NEWLINE SHALL clear the lock.
REQ-025 While the lock is set, only the locked requester SHALL be eligible; the other FIFO SHALL keep accepting pushes.
REQ-026 The lock timer SHALL count cycles spent in IDLE with the locked FIFO empty, and SHALL be cleared on any pop by the owner.
REQ-027 When the lock timer reaches LOCK_TIMEOUT, the lock SHALL clear and arbitration SHALL return to round-robin.
REQ-028 grant SHALL be non-zero from the pop until the return to IDLE, and SHALL stay non-zero while the lock is held; otherwise it SHALL be 0.
REQ-029 A push and a pop of the same FIFO in the same cycle SHALL leave the count unchanged and preserve order.

Reset
REQ-030 rst SHALL take effect immediately and asynchronously.
REQ-031 During reset: state IDLE; FIFOs empty; lock clear; lock timer 0; round-robin pointer set to requester 0.
REQ-032 During reset all outputs SHALL be 0 (tx_send, tx_data, grant, busyN, dropN).
REQ-033 A reset in the middle of a send SHALL abandon the in-flight character with no further tx_send.

Structure
REQ-034 FSM state encoding and the requester index constants SHALL live in a shared package, uart_pkg.
REQ-035 The FIFO SHALL be one sub-module, char_fifo, parameterised by DEPTH and instantiated twice, with a same-cycle push/pop rule.

Verification
REQ-036 Push 8'h41 on req0 with tx_ready held 1 -> tx_send at cycle +2 with tx_data=8'h41 and grant=2'b01.
REQ-037 Push "AB\n" on req0 and "xy\n" on req1 in the same cycles -> tx_data sequence 41,42,0A,78,79,0A; no interleaving.
REQ-038 Push 6 chars on req1 back-to-back with tx_ready=0 and DEPTH=4 -> busy1=1 after 4 pushes; drop1 pulses twice; first 4 chars sent in order once tx_ready=1.
REQ-039 Push 8'h41 on req0 (no newline), then req1 pushes 8'h5A -> 5A withheld for LOCK_TIMEOUT idle cycles, then sent with grant=2'b10.
REQ-040 Assert rst while in WAIT_HIGH -> all outputs 0 immediately; no tx_send after release until a new push.
